mc_main_ctrl: RTL and testbench
===============================

Name: mc_main_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS datapath; sequences fetch/decode/execute/memory/writeback.
- Drives the 3-bit ALUOp consumed by the ALU control decoder (000 add, 001 sub, 010 R-type/funct), plus mux selects and write strobes for PC, IR, register file and unified memory.
- Waits on a memory ready handshake and counts retired instructions for bring-up.

Parameters:
- CNT_W, 16, width of retired-instruction counter.
- OP_W, 6, opcode field width (fixed at 6 for MIPS; exposed for lint only).

Ports:
- clk  input  1  single system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Op  input  6  IR[31:26] opcode from instruction register.
- mem_ready  input  1  memory completes current read/write this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load qualified by ALU Zero (beq).
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  instruction register load.
- MemtoReg  output  1  reg write data: 0 = ALUOut, 1 = MDR.
- RegDst  output  1  dest reg: 0 = rt, 1 = rd.
- RegWrite  output  1  register file write enable.
- ALUSrcA  output  1  0 = PC, 1 = regA.
- ALUSrcB  output  2  00 regB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- ALUOp  output  3  to ALU control: 000 add, 001 sub, 010 use funct.
- PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target.
- state  output  4  current state encoding (debug).
- retired  output  CNT_W  instructions completed since reset, wraps at 2^CNT_W.
- illegal_op  output  1  sticky unsupported-opcode flag (see Optional Feature).

Behaviour:
- Reset: state=FETCH (0), retired=0, illegal_op=0; outputs follow FETCH decode with mem_ready gating (strobes low unless mem_ready). Reset mid-instruction abandons it; no writes issued during reset cycle.
- Outputs Moore (decoded from state) except PCWrite/IRWrite in FETCH, which are ANDed with mem_ready. All unlisted outputs 0 per state.
- Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11, TRAP 12; 13-15 -> FETCH next cycle.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00; IRWrite=PCWrite=mem_ready. Hold until mem_ready=1, then DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000 (branch target to ALUOut). Next by Op: 100011/101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDIEX; other -> FETCH (or TRAP with feature).
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=000; -> MEMRD if Op=100011 else MEMWR.
- MEMRD: MemRead=1, IorD=1; hold until mem_ready, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; -> FETCH, retired++.
- MEMWR: MemWrite=1, IorD=1; hold until mem_ready, then FETCH, retired++ on exit cycle.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=010; -> RWB. RWB: RegWrite=1, RegDst=1, MemtoReg=0; -> FETCH, retired++.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01; -> FETCH, retired++.
- JUMP: PCWrite=1, PCSource=10; -> FETCH, retired++.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=000; -> ADDIWB. ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0; -> FETCH, retired++.
- retired increments exactly once per completed instruction, wraps to 0 after all-ones; unsupported opcodes never increment it.
- Memory strobes held stable while waiting on mem_ready; mem_ready outside FETCH/MEMRD/MEMWR ignored.

Optional Feature:
- MC_ILLEGAL_TRAP_EN: defined -> unsupported Op in DECODE goes to TRAP; TRAP asserts no strobes, sets illegal_op=1 (sticky), stays until reset. Undefined -> unsupported Op returns to FETCH (treated as NOP, PC already advanced), illegal_op tied 0, TRAP unreachable (encoding 12 -> FETCH).

Decomposition:
- Shared package/include file mc_defs: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI), ALUOp constants (ALUOP_ADD 000, ALUOP_SUB 001, ALUOP_FUNCT 010), state encodings, ALUSrcB/PCSource codes; shared with the ALU control decoder.
- One sub-module natural: mc_ctrl_decode, purely combinational state -> control-word decode; FSM next-state, counter, sticky flag stay in top.

Test Plan:
- Reset held 2 cycles, mem_ready=1 -> state=0, retired=0, MemRead=1, IRWrite=1, PCWrite=1.
- Op=000000, mem_ready=1 always -> states 0,1,6,7,0; ALUOp=010 in EXEC; RegWrite=RegDst=1 in RWB; retired=1 after.
- Op=100011, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, MemRead=IorD=1 throughout, then MEMWB with MemtoReg=1, RegWrite=1.
- Op=000100 -> BRANCH with ALUOp=001, PCWriteCond=1, PCSource=01; Op=000010 -> JUMP with PCWrite=1, PCSource=10; each adds 1 to retired.
- Op=111111 -> without macro returns to FETCH, retired unchanged; with MC_ILLEGAL_TRAP_EN state=12, illegal_op=1 held until reset.
- CNT_W=4, 16 addi instructions -> retired wraps 15 -> 0; reset asserted mid-MEMWR -> no further MemWrite, state=0 next cycle.

Source files
------------

// File: rtl/mc_defs.sv
// rtl/mc_defs.sv - shared opcode, ALUOp, state and mux-select codes for the multi-cycle MIPS control path
package mc_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_RWB    = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9,
    ST_ADDIEX = 4'd10,
    ST_ADDIWB = 4'd11,
    ST_TRAP   = 4'd12
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic [1:0] pcsource;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - combinational state to control-word decode
module mc_ctrl_decode
  import mc_defs::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.memread  = 1'b1;
        ctrl.alusrcb  = SRCB_FOUR;
        ctrl.aluop    = ALUOP_ADD;
        ctrl.pcsource = PCSRC_ALU;
        // PC+4 and IR capture only on the cycle the fetch actually lands
        ctrl.irwrite  = mem_ready;
        ctrl.pcwrite  = mem_ready;
      end
      ST_DECODE: begin
        ctrl.alusrcb = SRCB_IMM_SH2;
        ctrl.aluop   = ALUOP_ADD;
      end
      ST_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      ST_MEMRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      ST_EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_REGB;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      ST_RWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alusrca     = 1'b1;
        ctrl.alusrcb     = SRCB_REGB;
        ctrl.aluop       = ALUOP_SUB;
        ctrl.pcwritecond = 1'b1;
        ctrl.pcsource    = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        ctrl.pcwrite  = 1'b1;
        ctrl.pcsource = PCSRC_JUMP;
      end
      ST_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      ST_ADDIWB: begin
        ctrl.regwrite = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// rtl/mc_main_ctrl.sv - multi-cycle MIPS main control FSM; MC_ILLEGAL_TRAP_EN enables the illegal-opcode trap
module mc_main_ctrl
  import mc_defs::*;
#(
  parameter int CNT_W = 16,
  parameter int OP_W  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  Op,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             illegal_op
);

  state_t           state_q;
  logic [CNT_W-1:0] retired_q;
  ctrl_t            ctrl;

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal_q;
  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      retired_q <= '0;
`ifdef MC_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_FETCH:  if (mem_ready) state_q <= ST_DECODE;
        ST_DECODE: begin
          case (Op)
            OP_LW, OP_SW: state_q <= ST_MEMADR;
            OP_RTYPE:     state_q <= ST_EXEC;
            OP_BEQ:       state_q <= ST_BRANCH;
            OP_J:         state_q <= ST_JUMP;
            OP_ADDI:      state_q <= ST_ADDIEX;
`ifdef MC_ILLEGAL_TRAP_EN
            default: begin
              state_q   <= ST_TRAP;
              illegal_q <= 1'b1;
            end
`else
            default:      state_q <= ST_FETCH;
`endif
          endcase
        end
        ST_MEMADR: state_q <= (Op == OP_LW) ? ST_MEMRD : ST_MEMWR;
        ST_MEMRD:  if (mem_ready) state_q <= ST_MEMWB;
        ST_MEMWR: begin
          if (mem_ready) begin
            state_q   <= ST_FETCH;
            retired_q <= retired_q + 1'b1;
          end
        end
        ST_EXEC:   state_q <= ST_RWB;
        ST_ADDIEX: state_q <= ST_ADDIWB;
        ST_MEMWB, ST_RWB, ST_BRANCH, ST_JUMP, ST_ADDIWB: begin
          state_q   <= ST_FETCH;
          retired_q <= retired_q + 1'b1;
        end
`ifdef MC_ILLEGAL_TRAP_EN
        ST_TRAP:   state_q <= ST_TRAP;
`endif
        default:   state_q <= ST_FETCH;
      endcase
    end
  end

  // Write strobes are suppressed while reset is asserted so an abandoned instruction never commits
  assign PCWrite     = ctrl.pcwrite     & ~reset;
  assign PCWriteCond = ctrl.pcwritecond & ~reset;
  assign MemWrite    = ctrl.memwrite    & ~reset;
  assign IRWrite     = ctrl.irwrite     & ~reset;
  assign RegWrite    = ctrl.regwrite    & ~reset;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.memread;
  assign MemtoReg    = ctrl.memtoreg;
  assign RegDst      = ctrl.regdst;
  assign ALUSrcA     = ctrl.alusrca;
  assign ALUSrcB     = ctrl.alusrcb;
  assign ALUOp       = ctrl.aluop;
  assign PCSource    = ctrl.pcsource;
  assign state       = state_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// tb/tb_mc_main_ctrl.sv - scoreboard bench for mc_main_ctrl
module tb_mc_main_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       Op;
  logic             mem_ready;
  logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic             MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]       ALUSrcB, PCSource;
  logic [2:0]       ALUOp;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired;
  logic             illegal_op;

  mc_main_ctrl #(.CNT_W(CNT_W), .OP_W(6)) dut (
    .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .retired(retired),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          st;
    logic [16:0] cw;
    int          ret;
    logic        ill;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   m_st   = 0;
  int   m_ret  = 0;
  logic m_ill  = 1'b0;

  wire [16:0] dut_cw = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                        MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [16:0] model_cw(input int st, input logic mr, input logic rst);
    logic pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
    {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, asa} = '0;
    asb = 2'b00; pcs = 2'b00; aop = 3'b000;
    case (st)
      0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin asa = 1; aop = 3'b010; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin asa = 1; aop = 3'b001; pcc = 1; pcs = 2'b01; end
      9:  begin pcw = 1; pcs = 2'b10; end
      10: begin asa = 1; asb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    if (rst) {pcw, pcc, mwr, irw, rw} = '0;
    return {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs};
  endfunction

  task automatic model_advance(input logic [5:0] op, input logic mr, input logic rst);
    int nx;
    logic done;
    nx = m_st; done = 1'b0;
    if (rst) begin
      m_st = 0; m_ret = 0; m_ill = 1'b0;
      return;
    end
    case (m_st)
      0:  if (mr) nx = 1;
      1: begin
        if (op == 6'b100011 || op == 6'b101011) nx = 2;
        else if (op == 6'b000000) nx = 6;
        else if (op == 6'b000100) nx = 8;
        else if (op == 6'b000010) nx = 9;
        else if (op == 6'b001000) nx = 10;
        else begin
`ifdef MC_ILLEGAL_TRAP_EN
          nx = 12; m_ill = 1'b1;
`else
          nx = 0;
`endif
        end
      end
      2:  nx = (op == 6'b100011) ? 3 : 5;
      3:  if (mr) nx = 4;
      5:  if (mr) begin nx = 0; done = 1; end
      6:  nx = 7;
      10: nx = 11;
      4, 7, 8, 9, 11: begin nx = 0; done = 1; end
      12: nx = 12;
      default: nx = 0;
    endcase
    m_st = nx;
    if (done) m_ret = (m_ret + 1) % (1 << CNT_W);
  endtask

  task automatic step(input logic [5:0] op, input logic mr, input logic rst);
    exp_t e;
    Op = op; mem_ready = mr; reset = rst;
    e.st = m_st; e.cw = model_cw(m_st, mr, rst); e.ret = m_ret; e.ill = m_ill;
    sbq.push_back(e);
    @(negedge clk);
    e = sbq.pop_front();
    check("state",   32'(state),      32'(e.st));
    check("ctrl",    32'(dut_cw),     32'(e.cw));
    check("retired", 32'(retired),    32'(e.ret));
    check("illegal", 32'(illegal_op), 32'(e.ill));
    model_advance(op, mr, rst);
    @(posedge clk); #1;
  endtask

  // mem_ready stays low for `stall` cycles in MEMRD/MEMWR and is random where it must be ignored
  task automatic run_instr(input logic [5:0] op, input int stall);
    int n, waited;
    logic mr;
    n = 0; waited = 0;
    do begin
      if (m_st == 0) mr = 1'b1;
      else if (m_st == 3 || m_st == 5) begin
        mr = (waited >= stall);
        waited++;
      end else mr = 1'($urandom_range(0, 1));
      step(op, mr, 1'b0);
      n++;
    end while (m_st != 0 && n < 40);
  endtask

  initial begin
    reset = 1'b1; Op = 6'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    step(6'b000000, 1'b1, 1'b1);
    step(6'b000000, 1'b1, 1'b1);

    run_instr(6'b000000, 0);
    run_instr(6'b100011, 3);
    run_instr(6'b101011, 2);
    run_instr(6'b000100, 0);
    run_instr(6'b000010, 0);

    for (int i = 0; i < 16; i++) run_instr(6'b001000, 0);

    step(6'b111111, 1'b1, 1'b0);
    step(6'b111111, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(6'b111111, 1'b0, 1'b0);
    step(6'b000000, 1'b1, 1'b1);
    step(6'b000000, 1'b1, 1'b1);

    run_instr(6'b000000, 0);
    step(6'b101011, 1'b1, 1'b0);
    step(6'b101011, 1'b1, 1'b0);
    step(6'b101011, 1'b1, 1'b0);
    step(6'b101011, 1'b0, 1'b0);
    step(6'b101011, 1'b0, 1'b0);
    step(6'b101011, 1'b0, 1'b1);
    step(6'b000000, 1'b0, 1'b0);
    step(6'b000000, 1'b1, 1'b0);
    run_instr(6'b000100, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
